// File: rtl/sumador_pipe.sv
// sumador_pipe: pipelined WIDTH-bit add/subtract with NZCV flags behind a valid/ready handshake
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake; in_ready = !out_valid | out_ready
//   A, B, sub, cin         operands; sub=1 computes A + ~B + cin (cin acts as borrow-not)
//   sat                    clamp on signed overflow instead of wrapping
//   out_valid / out_ready  result handshake
//   C, flag_n/z/c/v        registered result and NZCV flags
//
// Build option: SUMADOR_SAT_EN enables saturation; without it the sat port is ignored.
module sumador_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int SEG = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("sumador_pipe: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic             out_vld_q;
    logic [WIDTH-1:0] c_q;
    logic             n_q, z_q, cf_q, v_q;

    // The whole pipe moves as one: either every stage shifts or none does.
    assign adv       = !out_vld_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign C         = c_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_c    = cf_q;
    assign flag_v    = v_q;

`ifndef SUMADOR_SAT_EN
    logic unused_sat;
    assign unused_sat = sat;
`endif

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
        logic             c_in, v_in, co;
        logic [SEG-1:0]   seg;
        logic             unused_bits;
`ifdef SUMADOR_SAT_EN
        logic             sat_in;
`endif
        if (k == 0) begin : g_head
            assign a_in = A;
            assign b_in = sub ? ~B : B;
            assign s_in = '0;
            assign c_in = cin;
            assign v_in = in_valid;
`ifdef SUMADOR_SAT_EN
            assign sat_in = sat;
`endif
        end else begin : g_body
            assign a_in = g_stg[k-1].g_reg.a_q;
            assign b_in = g_stg[k-1].g_reg.b_q;
            assign s_in = g_stg[k-1].g_reg.s_q;
            assign c_in = g_stg[k-1].g_reg.cy_q;
            assign v_in = g_stg[k-1].g_reg.vld_q;
`ifdef SUMADOR_SAT_EN
            assign sat_in = g_stg[k-1].g_reg.sat_q;
`endif
        end

        // Operand bits below this segment were already consumed upstream.
        assign unused_bits = ^{a_in, b_in, s_in};

        assign {co, seg} = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]} + {{SEG{1'b0}}, c_in};

        always_comb begin
            s_d                = s_in;
            s_d[k*SEG +: SEG]  = seg;
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] a_q, b_q, s_q;
            logic             cy_q, vld_q;
`ifdef SUMADOR_SAT_EN
            logic             sat_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sat_q <= 1'b0;
                else if (adv && v_in) sat_q <= sat_in;
            end
`endif
            // Data only loads with a valid slot; bubbles move the valid bit alone.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    cy_q  <= 1'b0;
                end else if (adv) begin
                    vld_q <= v_in;
                    if (v_in) begin
                        a_q  <= a_in;
                        b_q  <= b_in;
                        s_q  <= s_d;
                        cy_q <= co;
                    end
                end
            end
        end else begin : g_tail
            logic             ci_msb, ovf;
            logic [WIDTH-1:0] res;
            assign ci_msb = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_d[WIDTH-1];
            assign ovf    = ci_msb ^ co;
`ifdef SUMADOR_SAT_EN
            // On overflow both addends share a_in's sign, which selects the clamp direction.
            assign res = (sat_in && ovf) ? {a_in[WIDTH-1], {(WIDTH-1){~a_in[WIDTH-1]}}} : s_d;
`else
            assign res = s_d;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_vld_q <= 1'b0;
                    c_q       <= '0;
                    n_q       <= 1'b0;
                    z_q       <= 1'b0;
                    cf_q      <= 1'b0;
                    v_q       <= 1'b0;
                end else if (adv) begin
                    out_vld_q <= v_in;
                    if (v_in) begin
                        c_q  <= res;
                        n_q  <= res[WIDTH-1];
                        z_q  <= (res == '0);
                        cf_q <= co;
                        v_q  <= ovf;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sumador_pipe.sv
// tb_sumador_pipe: directed self-checking bench for sumador_pipe (WIDTH=16, STAGES=2)
module tb_sumador_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] C;
    logic        flag_n, flag_z, flag_c, flag_v;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rx = 0;
    int          n_exp = 0;
    logic [19:0] exp_q[$];

    sumador_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub), .cin(cin), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .C(C),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every delivered result is matched in order against the hand-computed queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_rx++;
            if (exp_q.size() == 0) chk("unexpected_result", 32'(exp_q.size()), 32'd1);
            else chk("result", {12'h0, C, flag_n, flag_z, flag_c, flag_v}, {12'h0, exp_q.pop_front()});
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci,
                         input logic st, input logic [19:0] e, input logic keep, output int waits);
        A = a; B = b; sub = s; cin = ci; sat = st; in_valid = 1'b1;
        if (keep) begin
            exp_q.push_back(e);
            n_exp++;
        end
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int t;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        chk("rst_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0001, 4'b0000}, 1'b1, w);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("lat_C", 32'(C), 32'h0001);
        @(posedge clk); #1;

        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0002, 4'b0000}, 1'b1, w); chk("b2b_wait0", 32'(w), 32'd0);
        issue(16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0003, 4'b0000}, 1'b1, w); chk("b2b_wait1", 32'(w), 32'd0);
        issue(16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0004, 4'b0000}, 1'b1, w); chk("b2b_wait2", 32'(w), 32'd0);

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0000, 4'b0110}, 1'b1, w);
`ifdef SUMADOR_SAT_EN
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h7FFF, 4'b0001}, 1'b1, w);
`else
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h8000, 4'b1001}, 1'b1, w);
`endif
        issue(16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, {16'h0100, 4'b0000}, 1'b1, w);
        issue(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, {16'hFFFE, 4'b1000}, 1'b1, w);
        issue(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, {16'h0002, 4'b0010}, 1'b1, w);
`ifdef SUMADOR_SAT_EN
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, {16'h8000, 4'b1011}, 1'b1, w);
`else
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, {16'h7FFF, 4'b0011}, 1'b1, w);
`endif
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        issue(16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0011, 4'b0000}, 1'b1, w);
        issue(16'h0020, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0021, 4'b0000}, 1'b1, w);
        fork
            begin
                int w2;
                issue(16'h0030, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0031, 4'b0000}, 1'b1, w2);
                issue(16'h0040, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0041, 4'b0000}, 1'b1, w2);
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_head_C", 32'(C), 32'h0011);
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_C_stable", 32'(C), 32'h0011);
                    chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        issue(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, w);
        issue(16'h2222, 16'h2222, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, w);
        in_valid = 1'b0;
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_C", 32'(C), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0, {16'h000B, 4'b0000}, 1'b1, w);
        in_valid = 1'b0;
        @(negedge clk); chk("post_rst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk); chk("post_rst_lat2", 32'(out_valid), 32'd1);
        chk("post_rst_C", 32'(C), 32'h000B);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("received_count", 32'(n_rx), 32'(n_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
